// File: rtl/int_fp_mul_arbiter.sv
// rtl/int_fp_mul_arbiter.sv - round-robin sharing of one int8/fp16 multiplier among N requesters
module int_fp_mul_arbiter #(
  parameter int N   = 4,
  parameter int W   = 16,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N-1:0]   req_mode,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [N*W-1:0] rsp_data,
  output logic           mul_mode,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic           mul_issue,
  input  logic [W-1:0]   mul_c,
  output logic [3:0]     inflight
);
  localparam int IDW = $clog2(N);
  localparam int SW  = IDW + 1;

  logic [N-1:0]   busy;
  logic [N-1:0]   eligible;
  logic [IDW-1:0] rr;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [SW-1:0]  scan;

  logic [LAT:0]   trk_v;
  logic [IDW-1:0] trk_id [LAT+1];
  logic           cap;
  logic [IDW-1:0] cap_id;

  assign eligible = req_valid & ~busy;

  // Search eligible requesters starting at rr, wrapping modulo N.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan      = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, rr} + SW'(k);
      if (scan >= SW'(N)) scan = scan - SW'(N);
      if (!grant_any && eligible[scan[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && grant_any) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr        <= '0;
      mul_mode  <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_issue <= 1'b0;
    end else begin
      mul_issue <= grant_any;
      if (grant_any) begin
        rr       <= (grant_id == IDW'(N-1)) ? '0 : grant_id + 1'b1;
        mul_mode <= req_mode[grant_id];
        mul_a    <= req_a[int'(grant_id)*W +: W];
        mul_b    <= req_b[int'(grant_id)*W +: W];
      end
    end
  end

  // Tag pipeline: the entry reaching stage LAT lines up with mul_c for that operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_v <= '0;
      for (int k = 0; k <= LAT; k++) trk_id[k] <= '0;
    end else begin
      trk_v     <= {trk_v[LAT-1:0], grant_any};
      trk_id[0] <= grant_id;
      for (int k = 1; k <= LAT; k++) trk_id[k] <= trk_id[k-1];
    end
  end

  assign cap    = trk_v[LAT];
  assign cap_id = trk_id[LAT];

  // busy guarantees a slot is drained before it can be captured into again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cap && cap_id == IDW'(i)) begin
          rsp_valid[i]         <= 1'b1;
          rsp_data[i*W +: W]   <= mul_c;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
        if (req_ready[i]) busy[i] <= 1'b1;
        else if (rsp_valid[i] && rsp_ready[i]) busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else begin
      case ({grant_any, cap})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_int_fp_mul_arbiter.sv
// tb/tb_int_fp_mul_arbiter.sv - randomized and directed checks of int_fp_mul_arbiter against a queue model
module tb_int_fp_mul_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b, rsp_data;
  logic           mul_mode, mul_issue;
  logic [W-1:0]   mul_a, mul_b, mul_c;
  logic [3:0]     inflight;

  int errors = 0;
  int checks = 0;
  int max_inflight = 0;

  always #5 clk = ~clk;

  int_fp_mul_arbiter #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_mode(mul_mode), .mul_a(mul_a), .mul_b(mul_b), .mul_issue(mul_issue),
    .mul_c(mul_c), .inflight(inflight)
  );

  function automatic logic [15:0] mul_ref(logic mode, logic [15:0] a, logic [15:0] b);
    logic [21:0] m;
    logic        s;
    int          e;
    s = a[15] ^ b[15];
    if (!mode) return {8'h00, a[7:0]} * {8'h00, b[7:0]};
    if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {s, 15'h0};
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {s, 5'h1f, 10'h0};
    m = {11'h0, 1'b1, a[9:0]} * {11'h0, 1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (m[21]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 31) return {s, 5'h1f, 10'h0};
    if (e <= 0) return {s, 15'h0};
    return {s, 5'(e), m[19:10]};
  endfunction

  // Stand-in multiplier: LAT edges from operand update to a valid mul_c.
  logic [W-1:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= mul_ref(mul_mode, mul_a, mul_b);
    s2 <= s1;
  end
  assign mul_c = s2;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, logic [N-1:0] b, int from);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (from + k) % N;
      if (v[i] && !b[i]) return i;
    end
    return -1;
  endfunction

  int             m_rr, m_cyc;
  logic [N-1:0]   m_busy, m_rv;
  logic [N*W-1:0] m_rd;
  logic           m_mode, m_issue;
  logic [W-1:0]   m_a, m_b;
  int             q_id[$];
  int             q_due[$];
  logic [W-1:0]   q_res[$];

  task automatic model_clear();
    m_rr = 0; m_cyc = 0; m_busy = '0; m_rv = '0; m_rd = '0;
    m_mode = 1'b0; m_issue = 1'b0; m_a = '0; m_b = '0;
    q_id.delete(); q_due.delete(); q_res.delete();
  endtask

  initial begin : model
    int g, id;
    model_clear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_clear();
      end else begin
        m_cyc++;
        g = pick(req_valid, m_busy, m_rr);
        for (int i = 0; i < N; i++)
          if (m_rv[i] && rsp_ready[i]) begin
            m_rv[i] = 1'b0;
            m_busy[i] = 1'b0;
          end
        while (q_due.size() > 0 && q_due[0] == m_cyc) begin
          id = q_id.pop_front();
          void'(q_due.pop_front());
          m_rv[id] = 1'b1;
          m_rd[id*W +: W] = q_res.pop_front();
        end
        m_issue = (g >= 0);
        if (g >= 0) begin
          m_busy[g] = 1'b1;
          m_rr = (g + 1) % N;
          m_mode = req_mode[g];
          m_a = req_a[g*W +: W];
          m_b = req_b[g*W +: W];
          q_id.push_back(g);
          q_due.push_back(m_cyc + LAT + 1);
          q_res.push_back(mul_ref(m_mode, m_a, m_b));
        end
      end
    end
  end

  initial begin : compare
    logic [N-1:0] exp_ready;
    int g;
    forever begin
      @(negedge clk);
      exp_ready = '0;
      if (rst) begin
        g = pick(req_valid, m_busy, m_rr);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("rsp_data", rsp_data, m_rd);
      chk("mul_issue", mul_issue, m_issue);
      chk("mul_mode", mul_mode, m_mode);
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      chk("inflight", inflight, q_id.size());
      chk("inflight_bound", inflight <= 4'd3, 1'b1);
      if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(string tag, int id, logic mode, logic [15:0] a, logic [15:0] b, logic [15:0] exp);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[id] = 1'b1;
    req_valid = onehot;
    req_mode[id] = mode;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    tick();
    req_valid = '0;
    chk({tag, "_issue"}, mul_issue, 1'b1);
    chk({tag, "_mul_a"}, mul_a, a);
    tick();
    tick();
    chk({tag, "_early"}, rsp_valid, '0);
    tick();
    chk({tag, "_rsp_valid"}, rsp_valid, onehot);
    chk({tag, "_rsp_data"}, rsp_data[id*W +: W], exp);
    rsp_ready[id] = 1'b1;
    tick();
    rsp_ready = '0;
    chk({tag, "_drained"}, rsp_valid, '0);
  endtask

  logic [N-1:0] glog[$];
  logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [15:0]  bp_a, bp_b, bp_exp;
  logic         bp_mode;
  logic         found;

  initial begin : main
    req_valid = '0; req_mode = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    #1 rst = 1'b0;
    repeat (2) tick();
    chk("reset_rsp_valid", rsp_valid, '0);
    chk("reset_inflight", inflight, '0);
    chk("reset_mul_issue", mul_issue, 1'b0);
    req_valid = '1;
    #1 chk("reset_req_ready", req_ready, '0);
    req_valid = '0;
    rst = 1'b1;

    run_one("fp16", 0, 1'b1, 16'h3E00, 16'h4000, 16'h4200);
    run_one("int8", 2, 1'b0, 16'h0007, 16'h0009, 16'h003F);
    run_one("zero", 0, 1'b1, 16'h0000, 16'h4500, 16'h0000);

    // Round robin from a fresh reset.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 16'($urandom);
      req_b[i*W +: W] = 16'($urandom);
    end
    req_mode = 4'($urandom);
    req_valid = '1;
    rsp_ready = '1;
    max_inflight = 0;
    glog.delete();
    repeat (12) begin
      #1 if (req_ready != '0) glog.push_back(req_ready);
      tick();
    end
    chk("rr_grant_count", glog.size() >= 5, 1'b1);
    for (int k = 0; k < 5; k++)
      if (k < glog.size()) chk("rr_order", glog[k], rr_exp[k]);
    chk("rr_inflight_peak", max_inflight, 3);
    req_valid = '0;
    repeat (8) tick();

    // Backpressure on requester 1.
    bp_mode = 1'($urandom);
    bp_a = 16'($urandom);
    bp_b = 16'($urandom);
    bp_exp = mul_ref(bp_mode, bp_a, bp_b);
    req_mode[1] = bp_mode;
    req_a[W +: W] = bp_a;
    req_b[W +: W] = bp_b;
    rsp_ready = 4'b1001;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1011;
    repeat (3) tick();
    glog.delete();
    repeat (10) begin
      #1 chk("bp_no_grant1", req_ready[1], 1'b0);
      if (req_ready != '0) glog.push_back(req_ready);
      tick();
      chk("bp_rsp_valid1", rsp_valid[1], 1'b1);
      chk("bp_rsp_data1", rsp_data[W +: W], bp_exp);
    end
    chk("bp_grant_count", glog.size() >= 2, 1'b1);
    for (int k = 1; k < glog.size(); k++)
      chk("bp_alternate", glog[k] != glog[k-1] && (glog[k] == 4'b0001 || glog[k] == 4'b1000), 1'b1);
    rsp_ready[1] = 1'b1;
    #1 chk("bp_release_same_cycle", req_ready[1], 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      #1 if (req_ready[1]) found = 1'b1;
    end
    chk("bp_regrant", found, 1'b1);
    tick();
    req_valid = '0;
    rsp_ready = '1;
    repeat (8) tick();

    // Random traffic.
    repeat (400) begin
      req_valid = 4'($urandom);
      rsp_ready = 4'($urandom);
      req_mode = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = 16'($urandom);
        req_b[i*W +: W] = 16'($urandom);
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (10) tick();

    // Reset while two operations are in flight.
    rsp_ready = '0;
    req_a[0 +: W] = 16'h3C00;
    req_a[W +: W] = 16'h4400;
    req_b[0 +: 2*W] = {16'h4000, 16'h4000};
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '0;
    tick();
    rst = 1'b0;
    req_valid = 4'b0011;
    #1;
    chk("midrst_rsp_valid", rsp_valid, '0);
    chk("midrst_mul_issue", mul_issue, 1'b0);
    chk("midrst_inflight", inflight, '0);
    chk("midrst_mul_a", mul_a, '0);
    chk("midrst_req_ready", req_ready, '0);
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    repeat (6) begin
      tick();
      chk("midrst_no_stale_rsp", rsp_valid, '0);
    end
    req_valid = 4'b0101;
    #1 chk("midrst_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    rsp_ready = '1;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
